// File: rtl/l1_cache_arbiter.sv
// Shares one system-memory port between the L1 instruction and data caches.
// One line transaction is in flight at a time; responses return only to the requester.
module l1_cache_arbiter #(
   parameter int A_SZ   = 32,
   parameter int CL_LEN = 4
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  ic_req_valid,
   input  logic [A_SZ-1:0]       ic_req_addr,
   output logic                  ic_req_ready,
   output logic                  ic_rsp_valid,
   output logic [CL_LEN*32-1:0]  ic_rsp_data,
   input  logic                  dc_req_valid,
   input  logic                  dc_req_rw,
   input  logic [A_SZ-1:0]       dc_req_addr,
   input  logic [CL_LEN*32-1:0]  dc_req_wr_data,
   output logic                  dc_req_ready,
   output logic                  dc_rsp_valid,
   output logic [CL_LEN*32-1:0]  dc_rsp_data,
   output logic                  sm_req_valid,
   output logic                  sm_req_rw,
   output logic [A_SZ-1:0]       sm_req_addr,
   output logic [CL_LEN*32-1:0]  sm_req_wr_data,
   input  logic                  sm_req_ready,
   input  logic                  sm_rsp_valid,
   input  logic [CL_LEN*32-1:0]  sm_rsp_data
);

   localparam int LW  = CL_LEN * 32;
   localparam int OFS = $clog2(CL_LEN * 4);
   localparam logic [A_SZ-1:0] ADDR_MASK = {A_SZ{1'b1}} << OFS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DC = 1'b1
   } gnt_t;

   state_t            state_q, state_d;
   gnt_t              grant_q, grant_d;
   gnt_t              last_grant_q, last_grant_d;
   logic              ic_req_ready_q, ic_req_ready_d;
   logic              dc_req_ready_q, dc_req_ready_d;
   logic              ic_rsp_valid_q, ic_rsp_valid_d;
   logic              dc_rsp_valid_q, dc_rsp_valid_d;
   logic [LW-1:0]     ic_rsp_data_q, ic_rsp_data_d;
   logic [LW-1:0]     dc_rsp_data_q, dc_rsp_data_d;
   logic              sm_req_valid_q, sm_req_valid_d;
   logic              sm_req_rw_q, sm_req_rw_d;
   logic [A_SZ-1:0]   sm_req_addr_q, sm_req_addr_d;
   logic [LW-1:0]     sm_req_wr_data_q, sm_req_wr_data_d;
   logic              take_dc_s;
   logic              rsp_take_s;

   // Under contention the side not granted last time wins.
   assign take_dc_s = dc_req_valid & (~ic_req_valid | (last_grant_q == GNT_IC));

   // Next-state and registered-output computation for the transaction FSM.
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      last_grant_d     = last_grant_q;
      ic_req_ready_d   = 1'b0;
      dc_req_ready_d   = 1'b0;
      ic_rsp_valid_d   = 1'b0;
      dc_rsp_valid_d   = 1'b0;
      ic_rsp_data_d    = ic_rsp_data_q;
      dc_rsp_data_d    = dc_rsp_data_q;
      sm_req_valid_d   = 1'b0;
      sm_req_rw_d      = sm_req_rw_q;
      sm_req_addr_d    = sm_req_addr_q;
      sm_req_wr_data_d = sm_req_wr_data_q;
      rsp_take_s       = 1'b0;

      case (state_q)
         IDLE: begin
            if (ic_req_valid || dc_req_valid) begin
               if (take_dc_s) begin
                  dc_req_ready_d   = 1'b1;
                  grant_d          = GNT_DC;
                  last_grant_d     = GNT_DC;
                  sm_req_rw_d      = dc_req_rw;
                  sm_req_addr_d    = dc_req_addr & ADDR_MASK;
                  sm_req_wr_data_d = dc_req_wr_data;
               end else begin
                  ic_req_ready_d   = 1'b1;
                  grant_d          = GNT_IC;
                  last_grant_d     = GNT_IC;
                  sm_req_rw_d      = 1'b0;
                  sm_req_addr_d    = ic_req_addr & ADDR_MASK;
                  sm_req_wr_data_d = {LW{1'b0}};
               end
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            // First ISSUE cycle only raises sm_req_valid; handshake counts once it is visible.
            if (sm_req_valid_q && sm_req_ready) begin
               sm_req_valid_d = 1'b0;
               if (sm_rsp_valid) begin
                  rsp_take_s = 1'b1;
                  state_d    = RESP;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               sm_req_valid_d = 1'b1;
               state_d        = ISSUE;
            end
         end
         WAIT: begin
            if (sm_rsp_valid) begin
               rsp_take_s = 1'b1;
               state_d    = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rsp_take_s) begin
         if (grant_q == GNT_DC) begin
            dc_rsp_valid_d = 1'b1;
            dc_rsp_data_d  = sm_req_rw_q ? {LW{1'b0}} : sm_rsp_data;
         end else begin
            ic_rsp_valid_d = 1'b1;
            ic_rsp_data_d  = sm_rsp_data;
         end
      end else begin
         ic_rsp_valid_d = 1'b0;
         dc_rsp_valid_d = 1'b0;
      end
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q          <= IDLE;
         grant_q          <= GNT_IC;
         last_grant_q     <= GNT_IC;
         ic_req_ready_q   <= 1'b0;
         dc_req_ready_q   <= 1'b0;
         ic_rsp_valid_q   <= 1'b0;
         dc_rsp_valid_q   <= 1'b0;
         ic_rsp_data_q    <= {LW{1'b0}};
         dc_rsp_data_q    <= {LW{1'b0}};
         sm_req_valid_q   <= 1'b0;
         sm_req_rw_q      <= 1'b0;
         sm_req_addr_q    <= {A_SZ{1'b0}};
         sm_req_wr_data_q <= {LW{1'b0}};
      end else begin
         state_q          <= state_d;
         grant_q          <= grant_d;
         last_grant_q     <= last_grant_d;
         ic_req_ready_q   <= ic_req_ready_d;
         dc_req_ready_q   <= dc_req_ready_d;
         ic_rsp_valid_q   <= ic_rsp_valid_d;
         dc_rsp_valid_q   <= dc_rsp_valid_d;
         ic_rsp_data_q    <= ic_rsp_data_d;
         dc_rsp_data_q    <= dc_rsp_data_d;
         sm_req_valid_q   <= sm_req_valid_d;
         sm_req_rw_q      <= sm_req_rw_d;
         sm_req_addr_q    <= sm_req_addr_d;
         sm_req_wr_data_q <= sm_req_wr_data_d;
      end
   end

   assign ic_req_ready   = ic_req_ready_q;
   assign dc_req_ready   = dc_req_ready_q;
   assign ic_rsp_valid   = ic_rsp_valid_q;
   assign dc_rsp_valid   = dc_rsp_valid_q;
   assign ic_rsp_data    = ic_rsp_data_q;
   assign dc_rsp_data    = dc_rsp_data_q;
   assign sm_req_valid   = sm_req_valid_q;
   assign sm_req_rw      = sm_req_rw_q;
   assign sm_req_addr    = sm_req_addr_q;
   assign sm_req_wr_data = sm_req_wr_data_q;

endmodule

// File: tb/tb_l1_cache_arbiter.sv
// Directed, table-driven bench for l1_cache_arbiter: single transactions from a
// vector table plus hand-written contention, turnaround and mid-transaction reset sequences.
module tb_l1_cache_arbiter;

   localparam int A_SZ   = 32;
   localparam int CL_LEN = 4;
   localparam int LW     = CL_LEN * 32;

   logic            clk_in = 1'b0;
   logic            reset_in;
   logic            ic_req_valid;
   logic [A_SZ-1:0] ic_req_addr;
   logic            ic_req_ready;
   logic            ic_rsp_valid;
   logic [LW-1:0]   ic_rsp_data;
   logic            dc_req_valid;
   logic            dc_req_rw;
   logic [A_SZ-1:0] dc_req_addr;
   logic [LW-1:0]   dc_req_wr_data;
   logic            dc_req_ready;
   logic            dc_rsp_valid;
   logic [LW-1:0]   dc_rsp_data;
   logic            sm_req_valid;
   logic            sm_req_rw;
   logic [A_SZ-1:0] sm_req_addr;
   logic [LW-1:0]   sm_req_wr_data;
   logic            sm_req_ready;
   logic            sm_rsp_valid;
   logic [LW-1:0]   sm_rsp_data;

   always #5 clk_in = ~clk_in;

   l1_cache_arbiter #(.A_SZ(A_SZ), .CL_LEN(CL_LEN)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
      .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
      .dc_req_wr_data(dc_req_wr_data), .dc_req_ready(dc_req_ready),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
      .sm_req_valid(sm_req_valid), .sm_req_rw(sm_req_rw), .sm_req_addr(sm_req_addr),
      .sm_req_wr_data(sm_req_wr_data), .sm_req_ready(sm_req_ready),
      .sm_rsp_valid(sm_rsp_valid), .sm_rsp_data(sm_rsp_data)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ic_rdy_cnt = 0, dc_rdy_cnt = 0, ic_rsp_cnt = 0, dc_rsp_cnt = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Pulse counters sampled mid-cycle so every ready/response pulse is seen once.
   always @(negedge clk_in) begin
      if (ic_req_ready) ic_rdy_cnt <= ic_rdy_cnt + 1;
      if (dc_req_ready) dc_rdy_cnt <= dc_rdy_cnt + 1;
      if (ic_rsp_valid) ic_rsp_cnt <= ic_rsp_cnt + 1;
      if (dc_rsp_valid) dc_rsp_cnt <= dc_rsp_cnt + 1;
   end

   typedef struct {
      logic            ic_v;
      logic [31:0]     ic_a;
      logic            dc_v;
      logic            dc_rw;
      logic [31:0]     dc_a;
      logic [127:0]    dc_wd;
      logic [127:0]    mem;
      int              req_dly;
      int              rsp_dly;
      logic            exp_dc;
      logic            exp_rw;
      logic [31:0]     exp_addr;
      logic [127:0]    exp_wd;
      logic [127:0]    exp_rsp;
   } vec_t;

   vec_t tbl [5];
   vec_t vz, vm, c1d, c1i, c2d, c2i;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic apply_req(input vec_t v);
      if (v.ic_v) begin
         ic_req_valid = 1'b1;
         ic_req_addr  = v.ic_a;
      end
      if (v.dc_v) begin
         dc_req_valid   = 1'b1;
         dc_req_rw      = v.dc_rw;
         dc_req_addr    = v.dc_a;
         dc_req_wr_data = v.dc_wd;
      end
   endtask

   task automatic run_txn(input vec_t v, output int t_rdy);
      int  ic_r0, dc_r0, ic_p0, dc_p0;
      logic seen;
      ic_r0 = ic_rdy_cnt; dc_r0 = dc_rdy_cnt; ic_p0 = ic_rsp_cnt; dc_p0 = dc_rsp_cnt;
      t_rdy = cyc;
      seen  = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         if (ic_req_ready || dc_req_ready) seen = 1'b1;
      end
      chk("grant_seen", seen, 1'b1);
      if (!seen) begin
         ic_req_valid = 1'b0;
         dc_req_valid = 1'b0;
         return;
      end
      t_rdy = cyc;
      chk("grant_side", dc_req_ready, v.exp_dc);
      chk("grant_onehot", ic_req_ready & dc_req_ready, 1'b0);
      chk("sm_valid_at_accept", sm_req_valid, 1'b0);
      if (dc_req_ready) dc_req_valid = 1'b0;
      else              ic_req_valid = 1'b0;
      tick();
      chk("ready_one_cycle", ic_req_ready | dc_req_ready, 1'b0);
      chk("sm_req_valid", sm_req_valid, 1'b1);
      chk("sm_req_rw", sm_req_rw, v.exp_rw);
      chk("sm_req_addr", sm_req_addr, v.exp_addr);
      if (v.exp_rw) chk("sm_req_wr_data", sm_req_wr_data, v.exp_wd);
      for (int k = 0; k < v.req_dly; k++) begin
         tick();
         chk("bp_valid", sm_req_valid, 1'b1);
         chk("bp_addr", sm_req_addr, v.exp_addr);
         chk("bp_rw", sm_req_rw, v.exp_rw);
         if (v.exp_rw) chk("bp_wdata", sm_req_wr_data, v.exp_wd);
      end
      sm_req_ready = 1'b1;
      if (v.rsp_dly == 0) begin
         sm_rsp_valid = 1'b1;
         sm_rsp_data  = v.mem;
      end
      tick();
      sm_req_ready = 1'b0;
      sm_rsp_valid = 1'b0;
      chk("sm_valid_drop", sm_req_valid, 1'b0);
      if (v.rsp_dly > 0) begin
         for (int k = 1; k < v.rsp_dly; k++) begin
            chk("wait_no_reissue", sm_req_valid, 1'b0);
            chk("wait_no_rsp", ic_rsp_valid | dc_rsp_valid, 1'b0);
            tick();
         end
         sm_rsp_valid = 1'b1;
         sm_rsp_data  = v.mem;
         tick();
         sm_rsp_valid = 1'b0;
      end
      chk("rsp_latency", cyc - t_rdy, 2 + v.req_dly + v.rsp_dly);
      chk("ic_rsp_valid", ic_rsp_valid, !v.exp_dc);
      chk("dc_rsp_valid", dc_rsp_valid, v.exp_dc);
      if (v.exp_dc) chk("dc_rsp_data", dc_rsp_data, v.exp_rsp);
      else          chk("ic_rsp_data", ic_rsp_data, v.exp_rsp);
      tick();
      chk("rsp_one_cycle", ic_rsp_valid | dc_rsp_valid, 1'b0);
      chk("ic_ready_count", ic_rdy_cnt - ic_r0, v.exp_dc ? 0 : 1);
      chk("dc_ready_count", dc_rdy_cnt - dc_r0, v.exp_dc ? 1 : 0);
      chk("ic_rsp_count", ic_rsp_cnt - ic_p0, v.exp_dc ? 0 : 1);
      chk("dc_rsp_count", dc_rsp_cnt - dc_p0, v.exp_dc ? 1 : 0);
   endtask

   task automatic chk_all_reset(input string tag);
      chk({tag, "_ctrl"}, {ic_req_ready, ic_rsp_valid, dc_req_ready, dc_rsp_valid,
                           sm_req_valid, sm_req_rw}, 6'b000000);
      chk({tag, "_addr"}, sm_req_addr, 32'h0);
      chk({tag, "_wdata"}, sm_req_wr_data, 128'h0);
      chk({tag, "_ic_data"}, ic_rsp_data, 128'h0);
      chk({tag, "_dc_data"}, dc_rsp_data, 128'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t, t2, p_ic, p_dc, seen_r;
      reset_in = 1'b1;
      ic_req_valid = 1'b0; ic_req_addr = 32'h0;
      dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = 32'h0; dc_req_wr_data = 128'h0;
      sm_req_ready = 1'b0; sm_rsp_valid = 1'b0; sm_rsp_data = 128'h0;
      repeat (2) @(posedge clk_in);
      #1;
      chk_all_reset("reset");
      reset_in = 1'b0;

      //         ic_v  ic_a          dc_v  rw    dc_a          dc_wd                                   mem                                     rq rs dc    rw    addr          wd                                      rsp
      tbl[0] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,        128'h0,                                 128'h44443333_22221111_DEADBEEF_12345678, 0, 2, 1'b0, 1'b0, 32'h0000_0100, 128'h0,                                 128'h44443333_22221111_DEADBEEF_12345678};
      tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_2000, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 1, 1'b1, 1'b1, 32'h0000_2000, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 128'h0};
      tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_300C, 128'h0,                                 128'hCAFEBABE_0BADF00D_11223344_55667788, 0, 3, 1'b1, 1'b0, 32'h0000_3000, 128'h0,                                 128'hCAFEBABE_0BADF00D_11223344_55667788};
      tbl[3] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        128'h0,                                 128'h0F0E0D0C_0B0A0908_07060504_03020100, 5, 1, 1'b0, 1'b0, 32'hFFFF_FFF0, 128'h0,                                 128'h0F0E0D0C_0B0A0908_07060504_03020100};
      tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_4008, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A, 128'h99999999_88888888_77777777_66666666, 0, 0, 1'b1, 1'b1, 32'h0000_4000, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A, 128'h0};

      t = 0;
      for (int i = 0; i < 5; i++) begin
         apply_req(tbl[i]);
         run_txn(tbl[i], t);
      end

      // Back-to-back zero-wait requests: accept-to-accept spacing is the idle-to-idle time.
      vz = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 128'h0, 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978,
             0, 0, 1'b0, 1'b0, 32'h0000_0010, 128'h0, 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978};
      apply_req(vz);
      run_txn(vz, t2);
      chk("turnaround", t2 - t, 4);

      // Reset while waiting on memory for a D$ write-back.
      dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h0000_5000;
      dc_req_wr_data = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
      seen_r = 0;
      for (int n = 0; n < 20 && seen_r == 0; n++) begin
         tick();
         if (dc_req_ready) seen_r = 1;
      end
      chk("mid_grant_seen", seen_r, 1);
      dc_req_valid = 1'b0;
      tick();
      chk("mid_sm_valid", sm_req_valid, 1'b1);
      sm_req_ready = 1'b1;
      tick();
      sm_req_ready = 1'b0;
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      chk_all_reset("mid_reset");
      p_ic = ic_rsp_cnt; p_dc = dc_rsp_cnt;
      sm_rsp_valid = 1'b1;
      sm_rsp_data  = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
      tick();
      sm_rsp_valid = 1'b0;
      repeat (3) tick();
      chk("no_rsp_after_abort", (ic_rsp_cnt - p_ic) + (dc_rsp_cnt - p_dc), 0);
      chk("idle_after_abort", sm_req_valid, 1'b0);

      // Contention twice: DC then IC each round.
      c1d = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_6000, 128'h0, 128'h10101010_20202020_30303030_40404040,
              0, 1, 1'b1, 1'b0, 32'h0000_6000, 128'h0, 128'h10101010_20202020_30303030_40404040};
      c1i = '{1'b1, 32'h0000_7004, 1'b0, 1'b0, 32'h0, 128'h0, 128'h50505050_60606060_70707070_80808080,
              0, 1, 1'b0, 1'b0, 32'h0000_7000, 128'h0, 128'h50505050_60606060_70707070_80808080};
      c2d = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_801F, 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF, 128'h12121212_34343434_56565656_78787878,
              1, 2, 1'b1, 1'b1, 32'h0000_8010, 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF, 128'h0};
      c2i = '{1'b1, 32'h0000_9008, 1'b0, 1'b0, 32'h0, 128'h0, 128'h9A9A9A9A_BCBCBCBC_DEDEDEDE_F0F0F0F0,
              0, 0, 1'b0, 1'b0, 32'h0000_9000, 128'h0, 128'h9A9A9A9A_BCBCBCBC_DEDEDEDE_F0F0F0F0};
      apply_req(c1d);
      apply_req(c1i);
      run_txn(c1d, t);
      run_txn(c1i, t);
      apply_req(c2d);
      apply_req(c2i);
      run_txn(c2d, t);
      run_txn(c2i, t);

      // Fresh I$ request after everything settles.
      vm = '{1'b1, 32'h0000_0A0C, 1'b0, 1'b0, 32'h0, 128'h0, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE,
             2, 1, 1'b0, 1'b0, 32'h0000_0A00, 128'h0, 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE};
      apply_req(vm);
      run_txn(vm, t);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
